// File: rtl/tmds_channel_deskew_if.sv
// Signal bundle for the TMDS inter-channel deskew stage.
// The master drives receiver words; the slave returns deskewed words and lock status.
interface tmds_channel_deskew_if #(
    parameter int NCH   = 3,
    parameter int DEPTH = 8
);
    localparam int TW = $clog2(DEPTH);

    logic [NCH*10-1:0] ch_in;
    logic [NCH-1:0]    vld_in;
    logic [NCH*10-1:0] data_out;
    logic              aligned;
    logic [NCH*TW-1:0] taps;
    logic [7:0]        realign_cnt;
    logic [7:0]        fail_cnt;

    modport master (
        output ch_in, vld_in,
        input  data_out, aligned, taps, realign_cnt, fail_cnt
    );

    modport slave (
        input  ch_in, vld_in,
        output data_out, aligned, taps, realign_cnt, fail_cnt
    );
endinterface

// File: rtl/tmds_channel_deskew.sv
// Inter-channel TMDS deskew: times the blanking-end marker on every channel and
// delays each channel by a per-channel tap so all channels present the same pixel together.
module tmds_channel_deskew #(
    parameter int NCH      = 3,
    parameter int DEPTH    = 8,
    parameter int MIN_CTL  = 8,
    parameter int MAX_MISS = 4
) (
    input  logic                 clk,
    input  logic                 rst_raw_n,
    tmds_channel_deskew_if.slave bus
);
    localparam int TW = $clog2(DEPTH);
    localparam int RW = $clog2(MIN_CTL + 1);
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam logic [RW-1:0] RUN_FULL   = RW'(MIN_CTL);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISS);
    localparam logic [TW-1:0] W_LAST     = TW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARM, COLLECT, LOCKED} state_e;

    function automatic logic isCtl(input logic [9:0] word);
        return (word == 10'b1101010100) || (word == 10'b0010101011) ||
               (word == 10'b0101010100) || (word == 10'b1010101011);
    endfunction

    logic [9:0]        stage1_q [NCH];
    logic [9:0]        delay_q  [NCH][DEPTH-1];
    logic [RW-1:0]     runIn_q  [NCH];
    logic [RW-1:0]     runOut_q [NCH];
    logic [RW-1:0]     runIn_d  [NCH];
    logic [RW-1:0]     runOut_d [NCH];
    logic [NCH*10-1:0] dataOut_q;

    state_e            state_q;
    logic [TW-1:0]     taps_q    [NCH];
    logic [TW-1:0]     taps_d    [NCH];
    logic [TW-1:0]     arrival_q [NCH];
    logic [TW-1:0]     arrival_d [NCH];
    logic [NCH-1:0]    recorded_q;
    logic [NCH-1:0]    recorded_d;
    logic              winOpen_q;
    logic [TW-1:0]     winCnt_q;
    logic [MW-1:0]     miss_q;
    logic              aligned_q;
    logic [7:0]        realignCnt_q;
    logic [7:0]        failCnt_q;

    logic [9:0]        selWord [NCH];
    logic [NCH-1:0]    markIn;
    logic [NCH-1:0]    markOut;
    logic              winActive;
    logic [TW-1:0]     curW;
    logic [TW-1:0]     maxArr;
    logic              timeout;
    logic              allRecorded;

    // Tap 0 is the stage-1 word itself; tap k reads the word k cycles older.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            selWord[c] = stage1_q[c];
            for (int k = 1; k < DEPTH; k++) begin
                if (taps_q[c] == TW'(k)) selWord[c] = delay_q[c][k-1];
            end
            markIn[c]   = !isCtl(stage1_q[c]) && (runIn_q[c] == RUN_FULL);
            markOut[c]  = !isCtl(selWord[c]) && (runOut_q[c] == RUN_FULL);
            runIn_d[c]  = !isCtl(stage1_q[c]) ? '0 :
                          (runIn_q[c] == RUN_FULL) ? runIn_q[c] : runIn_q[c] + RW'(1);
            runOut_d[c] = !isCtl(selWord[c]) ? '0 :
                          (runOut_q[c] == RUN_FULL) ? runOut_q[c] : runOut_q[c] + RW'(1);
        end
    end

    always_comb begin
        winActive  = winOpen_q || (|markIn);
        curW       = winOpen_q ? winCnt_q : '0;
        recorded_d = recorded_q | markIn;
        maxArr     = '0;
        for (int c = 0; c < NCH; c++) begin
            arrival_d[c] = (markIn[c] && !recorded_q[c]) ? curW : arrival_q[c];
            if (recorded_d[c] && (arrival_d[c] > maxArr)) maxArr = arrival_d[c];
        end
        for (int c = 0; c < NCH; c++) begin
            taps_d[c] = maxArr - arrival_d[c];
        end
        timeout     = winActive && (curW == W_LAST) && !(&recorded_d);
        allRecorded = winActive && (&recorded_d);
    end

    always_ff @(posedge clk or negedge rst_raw_n) begin
        if (!rst_raw_n) begin
            dataOut_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                stage1_q[c] <= '0;
                runIn_q[c]  <= '0;
                runOut_q[c] <= '0;
                for (int k = 0; k < DEPTH - 1; k++) delay_q[c][k] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                stage1_q[c]   <= bus.ch_in[c*10 +: 10];
                delay_q[c][0] <= stage1_q[c];
                for (int k = 1; k < DEPTH - 1; k++) delay_q[c][k] <= delay_q[c][k-1];
                dataOut_q[c*10 +: 10] <= selWord[c];
                runIn_q[c]  <= runIn_d[c];
                runOut_q[c] <= runOut_d[c];
            end
        end
    end

    // A dropped word-lock overrides everything; window timeout outranks completion.
    always_ff @(posedge clk or negedge rst_raw_n) begin
        if (!rst_raw_n) begin
            state_q      <= IDLE;
            recorded_q   <= '0;
            winOpen_q    <= 1'b0;
            winCnt_q     <= '0;
            miss_q       <= '0;
            aligned_q    <= 1'b0;
            realignCnt_q <= '0;
            failCnt_q    <= '0;
            for (int c = 0; c < NCH; c++) begin
                taps_q[c]    <= '0;
                arrival_q[c] <= '0;
            end
        end else if (!(&bus.vld_in)) begin
            state_q   <= IDLE;
            aligned_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    aligned_q <= 1'b0;
                    state_q   <= ARM;
                end
                ARM: begin
                    aligned_q  <= 1'b0;
                    recorded_q <= '0;
                    winOpen_q  <= 1'b0;
                    winCnt_q   <= '0;
                    miss_q     <= '0;
                    state_q    <= COLLECT;
                end
                COLLECT: begin
                    aligned_q <= 1'b0;
                    if (winActive) begin
                        winOpen_q  <= 1'b1;
                        winCnt_q   <= curW + TW'(1);
                        recorded_q <= recorded_d;
                        arrival_q  <= arrival_d;
                        if (timeout) begin
                            if (failCnt_q != 8'hFF) failCnt_q <= failCnt_q + 8'd1;
                            state_q <= ARM;
                        end else if (allRecorded) begin
                            taps_q  <= taps_d;
                            state_q <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    aligned_q <= 1'b1;
                    if (&markOut) begin
                        miss_q <= '0;
                    end else if (|markOut) begin
                        if (miss_q + MW'(1) == MISS_LIMIT) begin
                            miss_q    <= '0;
                            aligned_q <= 1'b0;
                            state_q   <= ARM;
                            if (realignCnt_q != 8'hFF) realignCnt_q <= realignCnt_q + 8'd1;
                        end else begin
                            miss_q <= miss_q + MW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out    = dataOut_q;
    assign bus.aligned     = aligned_q;
    assign bus.realign_cnt = realignCnt_q;
    assign bus.fail_cnt    = failCnt_q;

    for (genvar c = 0; c < NCH; c++) begin : g_taps
        assign bus.taps[c*TW +: TW] = taps_q[c];
    end
endmodule
